// File: rtl/grant_sel_arbiter.sv
// grant_sel_arbiter: round-robin owner selection for a shared demux path with hold timeout
module grant_sel_arbiter #(
  parameter int SELECT_WIDTH = 3,
  parameter int HOLD_WIDTH   = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [2**SELECT_WIDTH-1:0]   Req,
  input  logic                         Done,
  output logic [SELECT_WIDTH-1:0]      GntSel,
  output logic                         GntValid,
  output logic [2**SELECT_WIDTH-1:0]   Gnt,
  output logic                         Timeout
);
  localparam int N = 2**SELECT_WIDTH;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arbState;
  arbState state, nextState;
  logic [SELECT_WIDTH-1:0] ptr, pick, idx;
  logic [HOLD_WIDTH-1:0] holdCnt;
  logic atLimit, normalRel, rel;
  assign atLimit   = holdCnt == '1;
  assign normalRel = Done | ~Req[GntSel];
  assign rel       = normalRel | atLimit;
  // first requester after ptr, scanning backwards so the nearest one wins; i=N wraps to ptr itself
  always_comb begin
    pick = ptr;
    idx  = '0;
    for (int i = N; i >= 1; i--) begin
      idx = ptr + SELECT_WIDTH'(i);
      if (Req[idx]) pick = idx;
    end
  end
  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  // next state: TURN always inserts one dead cycle between owners
  always_comb
    nextState = (state == IDLE)  ? (|Req ? GRANT : IDLE) :
                (state == GRANT) ? (rel ? TURN : GRANT) : IDLE;
  // outputs decoded from registered state and select only
  always_comb begin
    GntValid = state == GRANT;
    Gnt      = N'(GntValid) << GntSel;
  end
  // select, pointer, hold counter and timeout pulse; counter cannot pass T since T forces release
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      GntSel  <= '0;
      ptr     <= '1;
      holdCnt <= '0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= (state == GRANT) && atLimit && !normalRel;
      if (state == IDLE && |Req) begin
        GntSel  <= pick;
        holdCnt <= '0;
      end else if (state == GRANT) begin
        if (rel) ptr <= GntSel;
        else     holdCnt <= holdCnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_grant_sel_arbiter.sv
// tb_grant_sel_arbiter: directed vectors with hand-computed expectations
module tb_grant_sel_arbiter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [7:0] Req = 8'h00;
  logic Done = 1'b0;
  logic [2:0] GntSel;
  logic GntValid;
  logic [7:0] Gnt;
  logic Timeout;
  int vectors = 0;
  int miscompares = 0;

  grant_sel_arbiter #(.SELECT_WIDTH(3), .HOLD_WIDTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Done(Done),
    .GntSel(GntSel), .GntValid(GntValid), .Gnt(Gnt), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic grantAndRelease(input int expSel);
    tick();
    check("rr_sel", int'(GntSel), expSel);
    check("rr_valid", int'(GntValid), 1);
    check("rr_gnt", int'(Gnt), 1 << expSel);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("rr_dead1", int'(GntValid), 0);
    tick();
    check("rr_dead2", int'(GntValid), 0);
  endtask

  initial begin
    int seq[11] = '{4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6};
    tick();
    tick();
    check("rst_valid", int'(GntValid), 0);
    check("rst_gnt", int'(Gnt), 0);
    check("rst_sel", int'(GntSel), 0);
    check("rst_timeout", int'(Timeout), 0);
    Reset_n = 1'b1;
    Req = 8'h08;
    tick();
    check("single_sel", int'(GntSel), 3);
    check("single_gnt", int'(Gnt), 8'h08);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    Req = 8'h00;
    check("single_rel", int'(GntValid), 0);
    check("single_to", int'(Timeout), 0);
    check("single_hold_sel", int'(GntSel), 3);
    tick();
    Req = 8'hFF;
    foreach (seq[i]) grantAndRelease(seq[i]);
    Req = 8'h05;
    grantAndRelease(0);
    grantAndRelease(2);
    grantAndRelease(0);
    Req = 8'h02;
    tick();
    check("to_sel", int'(GntSel), 1);
    for (int i = 0; i < 15; i++) begin
      check("to_hold_valid", int'(GntValid), 1);
      check("to_hold_pulse", int'(Timeout), 0);
      tick();
    end
    check("to_last_valid", int'(GntValid), 1);
    tick();
    check("to_rel_valid", int'(GntValid), 0);
    check("to_pulse", int'(Timeout), 1);
    tick();
    check("to_pulse_end", int'(Timeout), 0);
    tick();
    check("to_regrant_sel", int'(GntSel), 1);
    check("to_regrant_valid", int'(GntValid), 1);
    tick();
    tick();
    Req = 8'h00;
    tick();
    check("wd_rel", int'(GntValid), 0);
    check("wd_to", int'(Timeout), 0);
    Req = 8'h02;
    tick();
    tick();
    check("co_sel", int'(GntSel), 1);
    for (int i = 0; i < 15; i++) tick();
    check("co_at_limit_valid", int'(GntValid), 1);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("co_rel", int'(GntValid), 0);
    check("co_to", int'(Timeout), 0);
    Req = 8'hFF;
    tick();
    tick();
    check("ar_sel", int'(GntSel), 2);
    check("ar_valid", int'(GntValid), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_valid_drop", int'(GntValid), 0);
    check("ar_gnt_drop", int'(Gnt), 0);
    check("ar_sel_clr", int'(GntSel), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("ar_first_sel", int'(GntSel), 0);
    check("ar_first_valid", int'(GntValid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
